// File: rtl/fsk_frame_sequencer.sv
// Assembles fixed-layout command frames from UART bytes, validates them, latches the fields
// and runs the FSK modulator when the payload matches the trigger word. All outputs are registered.
module fsk_frame_sequencer #(
  parameter int           FRAME_BYTES    = 19,
  parameter int           TIMEOUT_CYCLES = 120000,
  parameter logic [127:0] TRIGGER_WORD   = 128'h1234_1234_1234_1234_1234_1234_1234_1234
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         mod_done,
  output logic [127:0] payload,
  output logic [15:0]  symbol_time,
  output logic [3:0]   rep_factor,
  output logic         frame_valid,
  output logic         tx_start,
  output logic         mod_start,
  output logic         busy,
  output logic         frame_error,
  output logic         rx_overrun
);

  localparam int SH_W  = 8 * FRAME_BYTES;
  localparam int CNT_W = $clog2(FRAME_BYTES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_MODULATE} state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [127:0]      payload_q, payload_d;
  logic [15:0]       symbol_time_q, symbol_time_d;
  logic [3:0]        rep_factor_q, rep_factor_d;
  logic              frame_valid_q, frame_valid_d;
  logic              tx_start_q, tx_start_d;
  logic              mod_start_q, mod_start_d;
  logic              busy_q, busy_d;
  logic              frame_error_q, frame_error_d;
  logic              rx_overrun_q, rx_overrun_d;

  // Byte 0 sits at the top of the shift register once the whole frame is in.
  logic [127:0] frm_payload;
  logic [15:0]  frm_symbol;
  logic [3:0]   frm_rep;
  assign frm_payload = shreg_q[SH_W-1 -: 128];
  assign frm_symbol  = shreg_q[23:8];
  assign frm_rep     = shreg_q[3:0];

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_d         = tmo_q;
    payload_d     = payload_q;
    symbol_time_d = symbol_time_q;
    rep_factor_d  = rep_factor_q;
    mod_start_d   = mod_start_q;
    frame_valid_d = 1'b0;
    tx_start_d    = 1'b0;
    frame_error_d = 1'b0;
    rx_overrun_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          shreg_d    = {shreg_q[SH_W-9:0], rx_data};
          byte_cnt_d = CNT_W'(1);
          tmo_d      = '0;
          state_d    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A byte arriving in the expiry cycle keeps the frame alive.
        if (rx_valid) begin
          shreg_d    = {shreg_q[SH_W-9:0], rx_data};
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          tmo_d      = '0;
          if (byte_cnt_q == LAST_BYTE) state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          frame_error_d = 1'b1;
          byte_cnt_d    = '0;
          tmo_d         = '0;
          state_d       = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_CHECK: begin
        rx_overrun_d = rx_valid;
        byte_cnt_d   = '0;
        tmo_d        = '0;
        state_d      = S_IDLE;
        if (frm_symbol == 16'h0 || frm_rep == 4'h0) begin
          frame_error_d = 1'b1;
        end else begin
          payload_d     = frm_payload;
          symbol_time_d = frm_symbol;
          rep_factor_d  = frm_rep;
          frame_valid_d = 1'b1;
          tx_start_d    = 1'b1;
          if (frm_payload == TRIGGER_WORD) begin
            mod_start_d = 1'b1;
            state_d     = S_MODULATE;
          end
        end
      end
      S_MODULATE: begin
        rx_overrun_d = rx_valid;
        if (mod_done) begin
          mod_start_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      byte_cnt_q    <= '0;
      tmo_q         <= '0;
      payload_q     <= '0;
      symbol_time_q <= '0;
      rep_factor_q  <= '0;
      frame_valid_q <= 1'b0;
      tx_start_q    <= 1'b0;
      mod_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_q         <= tmo_d;
      payload_q     <= payload_d;
      symbol_time_q <= symbol_time_d;
      rep_factor_q  <= rep_factor_d;
      frame_valid_q <= frame_valid_d;
      tx_start_q    <= tx_start_d;
      mod_start_q   <= mod_start_d;
      busy_q        <= busy_d;
      frame_error_q <= frame_error_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

  assign payload     = payload_q;
  assign symbol_time = symbol_time_q;
  assign rep_factor  = rep_factor_q;
  assign frame_valid = frame_valid_q;
  assign tx_start    = tx_start_q;
  assign mod_start   = mod_start_q;
  assign busy        = busy_q;
  assign frame_error = frame_error_q;
  assign rx_overrun  = rx_overrun_q;

endmodule

// File: tb/tb_fsk_frame_sequencer.sv
// Directed bench for fsk_frame_sequencer with a shortened frame timeout.
module tb_fsk_frame_sequencer;

  localparam int           TMO  = 50;
  localparam logic [127:0] TRIG = 128'h1234_1234_1234_1234_1234_1234_1234_1234;
  localparam logic [127:0] PL_A = 128'hAADEADBEEF0123456789ABCDEF001122;
  localparam logic [127:0] PL_B = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] PL_C = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   rx_data = 8'h0;
  logic         rx_valid = 1'b0;
  logic         mod_done = 1'b0;
  logic [127:0] payload;
  logic [15:0]  symbol_time;
  logic [3:0]   rep_factor;
  logic         frame_valid, tx_start, mod_start, busy, frame_error, rx_overrun;

  int checks = 0;
  int failures = 0;

  fsk_frame_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .mod_done(mod_done),
    .payload(payload), .symbol_time(symbol_time), .rep_factor(rep_factor),
    .frame_valid(frame_valid), .tx_start(tx_start), .mod_start(mod_start), .busy(busy),
    .frame_error(frame_error), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input logic [151:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx_data  = f[151-8*i -: 8];
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
  endtask

  // Returns right after the edge that samples the last byte (the CHECK cycle).
  task automatic send_frame(input logic [127:0] pl, input logic [15:0] st, input logic [7:0] b18);
    send_bytes({pl, st, b18}, 19);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if ({frame_valid, tx_start, mod_start, busy, frame_error, rx_overrun} !== 6'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 000000", {frame_valid, tx_start, mod_start, busy, frame_error, rx_overrun}); end
    checks++; if ({payload, symbol_time, rep_factor} !== 148'h0) begin
      failures++; $display("FAIL reset_fields: got %h expected 0", {payload, symbol_time, rep_factor}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_trigger();
    bit held;
    send_frame(TRIG, 16'h0100, 8'h03);
    checks++; if ({frame_valid, tx_start, busy} !== 3'b001) begin
      failures++; $display("FAIL trig_check_cycle: got %b expected 001", {frame_valid, tx_start, busy}); end
    tick();
    checks++; if ({frame_valid, tx_start, mod_start, busy} !== 4'b1111) begin
      failures++; $display("FAIL trig_pulses: got %b expected 1111", {frame_valid, tx_start, mod_start, busy}); end
    checks++; if (payload !== TRIG || symbol_time !== 16'h0100 || rep_factor !== 4'h3) begin
      failures++; $display("FAIL trig_fields: got %h %h %h expected %h 0100 3", payload, symbol_time, rep_factor, TRIG); end
    held = 1'b1;
    for (int i = 0; i < 499; i++) begin
      tick();
      if (mod_start !== 1'b1 || frame_valid !== 1'b0 || tx_start !== 1'b0) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin
      failures++; $display("FAIL trig_mod_hold: got %b expected 1", held); end
    mod_done = 1'b1;
    tick();
    mod_done = 1'b0;
    checks++; if ({mod_start, busy} !== 2'b00) begin
      failures++; $display("FAIL trig_mod_done: got %b expected 00", {mod_start, busy}); end
  endtask

  task automatic test_non_trigger();
    send_frame(PL_A, 16'h0010, 8'h01);
    tick();
    checks++; if ({frame_valid, tx_start, mod_start, busy} !== 4'b1100) begin
      failures++; $display("FAIL ntrig_pulses: got %b expected 1100", {frame_valid, tx_start, mod_start, busy}); end
    checks++; if (payload !== PL_A || symbol_time !== 16'h0010 || rep_factor !== 4'h1) begin
      failures++; $display("FAIL ntrig_fields: got %h %h %h expected %h 0010 1", payload, symbol_time, rep_factor, PL_A); end
    tick();
    checks++; if ({frame_valid, tx_start} !== 2'b00) begin
      failures++; $display("FAIL ntrig_pulse_width: got %b expected 00", {frame_valid, tx_start}); end
  endtask

  task automatic test_timeout();
    bit quiet;
    send_bytes({PL_B, 16'h1234, 8'hF7}, 10);
    quiet = 1'b1;
    for (int i = 1; i < TMO; i++) begin
      tick();
      if (frame_error !== 1'b0 || busy !== 1'b1) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin
      failures++; $display("FAIL tmo_early: got %b expected 1", quiet); end
    tick();
    checks++; if ({frame_error, busy} !== 2'b10) begin
      failures++; $display("FAIL tmo_expire: got %b expected 10", {frame_error, busy}); end
    tick();
    checks++; if (frame_error !== 1'b0) begin
      failures++; $display("FAIL tmo_pulse_width: got %b expected 0", frame_error); end
    // A byte in the expiry cycle keeps the partial frame and restarts the count.
    send_bytes({PL_C, 16'h0001, 8'h01}, 3);
    for (int i = 1; i < TMO; i++) tick();
    send_bytes({8'h77, 144'h0}, 1);
    checks++; if ({frame_error, busy} !== 2'b01) begin
      failures++; $display("FAIL tmo_byte_wins: got %b expected 01", {frame_error, busy}); end
    for (int i = 1; i < TMO; i++) tick();
    tick();
    checks++; if (frame_error !== 1'b1) begin
      failures++; $display("FAIL tmo_restart: got %b expected 1", frame_error); end
    tick();
    send_frame(PL_B, 16'h1234, 8'hF7);
    tick();
    checks++; if (frame_valid !== 1'b1 || payload !== PL_B || symbol_time !== 16'h1234 || rep_factor !== 4'h7) begin
      failures++; $display("FAIL tmo_recover: got %b %h %h %h expected 1 %h 1234 7", frame_valid, payload, symbol_time, rep_factor, PL_B); end
  endtask

  task automatic test_reject();
    send_frame(PL_C, 16'h0000, 8'h05);
    tick();
    checks++; if ({frame_error, frame_valid, tx_start, mod_start, busy} !== 5'b10000) begin
      failures++; $display("FAIL rej_sym_flags: got %b expected 10000", {frame_error, frame_valid, tx_start, mod_start, busy}); end
    checks++; if (payload !== PL_B || symbol_time !== 16'h1234 || rep_factor !== 4'h7) begin
      failures++; $display("FAIL rej_sym_hold: got %h %h %h expected %h 1234 7", payload, symbol_time, rep_factor, PL_B); end
    send_frame(PL_C, 16'h0040, 8'hF0);
    tick();
    checks++; if ({frame_error, tx_start} !== 2'b10 || payload !== PL_B) begin
      failures++; $display("FAIL rej_rep: got %b %h expected 10 %h", {frame_error, tx_start}, payload, PL_B); end
  endtask

  task automatic test_overrun();
    bit all_pulsed;
    send_frame(TRIG, 16'h0200, 8'h02);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    checks++; if ({rx_overrun, frame_valid, mod_start} !== 3'b111) begin
      failures++; $display("FAIL ovr_check: got %b expected 111", {rx_overrun, frame_valid, mod_start}); end
    tick();
    checks++; if (rx_overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_idle: got %b expected 0", rx_overrun); end
    all_pulsed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data  = 8'hA0 + 8'(i);
      rx_valid = 1'b1;
      tick();
      if (rx_overrun !== 1'b1) all_pulsed = 1'b0;
    end
    rx_valid = 1'b0;
    tick();
    checks++; if (all_pulsed !== 1'b1 || rx_overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_modulate: got %b %b expected 1 0", all_pulsed, rx_overrun); end
    checks++; if ({mod_start, busy} !== 2'b11 || payload !== TRIG || symbol_time !== 16'h0200 || rep_factor !== 4'h2) begin
      failures++; $display("FAIL ovr_state: got %b %h %h %h expected 11", {mod_start, busy}, payload, symbol_time, rep_factor); end
    mod_done = 1'b1;
    tick();
    mod_done = 1'b0;
    checks++; if ({mod_start, busy} !== 2'b00) begin
      failures++; $display("FAIL ovr_done: got %b expected 00", {mod_start, busy}); end
  endtask

  task automatic test_back_to_back();
    send_frame(PL_A, 16'h0033, 8'h04);
    tick();
    checks++; if (frame_valid !== 1'b1 || payload !== PL_A) begin
      failures++; $display("FAIL b2b_first: got %b %h expected 1 %h", frame_valid, payload, PL_A); end
    send_frame(PL_C, 16'h0044, 8'h05);
    tick();
    checks++; if (frame_valid !== 1'b1 || payload !== PL_C || symbol_time !== 16'h0044 || rep_factor !== 4'h5) begin
      failures++; $display("FAIL b2b_second: got %b %h %h %h expected 1 %h 0044 5", frame_valid, payload, symbol_time, rep_factor, PL_C); end
  endtask

  task automatic test_reset_mid();
    send_frame(TRIG, 16'h0300, 8'h04);
    tick();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (mod_start !== 1'b1) begin
      failures++; $display("FAIL rst_pre: got %b expected 1", mod_start); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({frame_valid, tx_start, mod_start, busy, frame_error, rx_overrun} !== 6'b0 || payload !== 128'h0) begin
      failures++; $display("FAIL rst_mid_mod: got %b %h expected 000000 0", {frame_valid, tx_start, mod_start, busy, frame_error, rx_overrun}, payload); end
    send_bytes({PL_C, 16'h0001, 8'h01}, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid_frame: got %b expected 0", busy); end
    send_frame(PL_A, 16'h0055, 8'h06);
    tick();
    checks++; if (frame_valid !== 1'b1 || payload !== PL_A || symbol_time !== 16'h0055 || rep_factor !== 4'h6) begin
      failures++; $display("FAIL rst_recover: got %b %h %h %h expected 1 %h 0055 6", frame_valid, payload, symbol_time, rep_factor, PL_A); end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_non_trigger();
    test_timeout();
    test_reject();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
